if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register plus a 2-entry {pc, inst, exc} FIFO in front of decode.
// Build option FETCH_MISALIGN_EXC_EN: misaligned redirects raise a fetch fault instead of being aligned down.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ce_o,
  output logic [31:0] addr_o,
  input  logic [31:0] inst_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        exc_o
);

  // state | meaning
  // RUN   | fetching sequentially whenever the FIFO has room
  // FAULT | misaligned redirect taken; fetch halted until the next flush
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  entry_t      e0_q, e0_d;  // e0 is always the head
  entry_t      e1_q, e1_d;
  logic        pop, fire;
  entry_t      new_e;

  always_comb begin
    valid_o = !rst && (cnt_q != 2'd0);
    pop     = valid_o && ready_i;
    fire    = !rst && (state_q == RUN) && !flush_i && ((cnt_q != 2'd2) || pop);
    ce_o    = fire;
    addr_o  = pc_q;
    new_e   = '{pc: pc_q, inst: inst_i, exc: 1'b0};
    if (valid_o) begin
      pc_o   = e0_q.pc;
      inst_o = e0_q.inst;
    end else begin
      pc_o   = 32'h0;
      inst_o = NOP;
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  assign exc_o = valid_o ? e0_q.exc : 1'b0;
`else
  logic unused_bits;
  assign unused_bits = ^{target_i[1:0], e0_q.exc};
  assign exc_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush_i) begin
      cnt_d = 2'd0;
`ifdef FETCH_MISALIGN_EXC_EN
      if (target_i[1:0] != 2'b00) begin
        cnt_d   = 2'd1;
        e0_d    = '{pc: target_i, inst: NOP, exc: 1'b1};
        pc_d    = target_i;
        state_d = FAULT;
      end else begin
        pc_d    = target_i;
        state_d = RUN;
      end
`else
      pc_d    = {target_i[31:2], 2'b00};
      state_d = RUN;
`endif
    end else begin
      unique case ({pop, fire})
        2'b11: begin
          // count is unchanged; at count=1 the new word replaces the head
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = new_e;
          end else begin
            e0_d = new_e;
          end
        end
        2'b10: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) e0_d = new_e;
          else               e1_d = new_e;
          cnt_d = cnt_q + 2'd1;
        end
        default: ;
      endcase
      if (fire) pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule
